spm_load_splitter: RTL and testbench



---
 rtl/std_cache_pkg.sv | 46 ++++
 rtl/spm_load_splitter.sv | 165 ++++++++++++++++
 tb/tb_spm_load_splitter.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/std_cache_pkg.sv
// Shared dcache/SPM request types, splitter state encoding and the SPM window match.
// SPM_SPLIT_RSP_REG_EN adds the LD_RSP state used by the registered-response build.
package std_cache_pkg;

  localparam int unsigned DCACHE_INDEX_WIDTH = 12;
  localparam int unsigned DCACHE_TAG_WIDTH   = 44;

  typedef struct packed {
    logic [DCACHE_INDEX_WIDTH-1:0] address_index;
    logic [DCACHE_TAG_WIDTH-1:0]   address_tag;
    logic [63:0]                   data_wdata;
    logic                          data_req;
    logic                          data_we;
    logic [7:0]                    data_be;
    logic [1:0]                    data_size;
    logic                          kill_req;
    logic                          tag_valid;
  } dcache_req_i_t;

  typedef struct packed {
    logic        data_gnt;
    logic        data_rvalid;
    logic [63:0] data_rdata;
  } dcache_req_o_t;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_TAG,
    LD_REQ,
    ST_REQ,
`ifdef SPM_SPLIT_RSP_REG_EN
    OOW_RSP,
    LD_RSP
`else
    OOW_RSP
`endif
  } spm_split_state_e;

  // SPM_BASE must be aligned to SPM_SIZE, and SPM_SIZE must be a power of two.
  function automatic logic spm_in_window(input logic [63:0] addr,
                                         input logic [63:0] base,
                                         input logic [63:0] size);
    return (addr & ~(size - 64'd1)) == base;
  endfunction

endpackage

// File: rtl/spm_load_splitter.sv
// Folds the two-phase dcache load (index, then tag) into one SPM request and window-checks stores.
// Optional macro SPM_SPLIT_RSP_REG_EN registers load/OOW responses for one extra cycle.
module spm_load_splitter
  import std_cache_pkg::*;
#(
  parameter int unsigned IDX_WIDTH = DCACHE_INDEX_WIDTH,
  parameter int unsigned TAG_WIDTH = DCACHE_TAG_WIDTH,
  parameter logic [63:0] SPM_BASE  = 64'h0000_0000_7000_0000,
  parameter logic [63:0] SPM_SIZE  = 64'h0000_0000_0002_0000,
  parameter logic [63:0] OOW_RDATA = 64'hCA11AB1E_BADCAB1E
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  dcache_req_i_t core_req_i,
  output dcache_req_o_t core_req_o,
  output dcache_req_i_t spm_req_o,
  input  dcache_req_o_t spm_req_i,
  output logic          busy_o
);

  localparam int unsigned PadWidth = 64 - TAG_WIDTH - IDX_WIDTH;

  spm_split_state_e     state_q, state_d;
  logic [IDX_WIDTH-1:0] idx_q, idx_d;
  logic [TAG_WIDTH-1:0] tag_q, tag_d;
  logic [63:0]          wdata_q, wdata_d;
  logic [7:0]           be_q, be_d;
  logic [1:0]           size_q, size_d;
`ifdef SPM_SPLIT_RSP_REG_EN
  logic [63:0]          rdata_q, rdata_d;
`endif

  logic [63:0] storeAddr, loadAddr;

  // Stores carry the tag with the index; loads pair the live tag with the captured index.
  assign storeAddr = {{PadWidth{1'b0}}, core_req_i.address_tag, core_req_i.address_index};
  assign loadAddr  = {{PadWidth{1'b0}}, core_req_i.address_tag, idx_q};
  assign busy_o    = (state_q != IDLE);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      idx_q   <= '0;
      tag_q   <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      size_q  <= '0;
`ifdef SPM_SPLIT_RSP_REG_EN
      rdata_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      tag_q   <= tag_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      size_q  <= size_d;
`ifdef SPM_SPLIT_RSP_REG_EN
      rdata_q <= rdata_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    tag_d      = tag_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    size_d     = size_q;
`ifdef SPM_SPLIT_RSP_REG_EN
    rdata_d    = rdata_q;
`endif
    core_req_o = '0;
    spm_req_o  = '0;

    unique case (state_q)
      IDLE: begin
        if (core_req_i.data_req) begin
          idx_d  = core_req_i.address_index;
          be_d   = core_req_i.data_be;
          size_d = core_req_i.data_size;
          if (!core_req_i.data_we) begin
            core_req_o.data_gnt = 1'b1;
            state_d             = WAIT_TAG;
          end else begin
            tag_d   = core_req_i.address_tag;
            wdata_d = core_req_i.data_wdata;
            // Out-of-window stores are acknowledged and silently dropped.
            if (spm_in_window(storeAddr, SPM_BASE, SPM_SIZE)) begin
              state_d = ST_REQ;
            end else begin
              core_req_o.data_gnt = 1'b1;
            end
          end
        end
      end

      WAIT_TAG: begin
        if (core_req_i.kill_req) begin
          state_d = IDLE;
        end else if (core_req_i.tag_valid) begin
          tag_d   = core_req_i.address_tag;
          state_d = spm_in_window(loadAddr, SPM_BASE, SPM_SIZE) ? LD_REQ : OOW_RSP;
        end
      end

      LD_REQ: begin
        spm_req_o.address_index = idx_q;
        spm_req_o.address_tag   = tag_q;
        spm_req_o.data_be       = be_q;
        spm_req_o.data_size     = size_q;
        spm_req_o.tag_valid     = 1'b1;
        spm_req_o.data_req      = !spm_req_i.data_rvalid;
        if (spm_req_i.data_rvalid) begin
`ifdef SPM_SPLIT_RSP_REG_EN
          rdata_d = spm_req_i.data_rdata;
          state_d = LD_RSP;
`else
          core_req_o.data_rvalid = 1'b1;
          core_req_o.data_rdata  = spm_req_i.data_rdata;
          state_d                = IDLE;
`endif
        end
      end

      ST_REQ: begin
        spm_req_o.address_index = idx_q;
        spm_req_o.address_tag   = tag_q;
        spm_req_o.data_wdata    = wdata_q;
        spm_req_o.data_be       = be_q;
        spm_req_o.data_size     = size_q;
        spm_req_o.tag_valid     = 1'b1;
        spm_req_o.data_we       = 1'b1;
        spm_req_o.data_req      = 1'b1;
        if (spm_req_i.data_gnt) begin
          core_req_o.data_gnt = 1'b1;
          state_d             = IDLE;
        end
      end

      OOW_RSP: begin
`ifdef SPM_SPLIT_RSP_REG_EN
        rdata_d = OOW_RDATA;
        state_d = LD_RSP;
`else
        core_req_o.data_rvalid = 1'b1;
        core_req_o.data_rdata  = OOW_RDATA;
        state_d                = IDLE;
`endif
      end

`ifdef SPM_SPLIT_RSP_REG_EN
      LD_RSP: begin
        core_req_o.data_rvalid = 1'b1;
        core_req_o.data_rdata  = rdata_q;
        state_d                = IDLE;
      end
`endif

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_spm_load_splitter.sv
// Directed bench for spm_load_splitter: in-window/killed/out-of-window loads, stores, reset mid-load.
module tb_spm_load_splitter;
  import std_cache_pkg::*;

  logic          clk_i;
  logic          rst_i;
  dcache_req_i_t coreReq;
  dcache_req_o_t coreRsp;
  dcache_req_i_t spmReq;
  dcache_req_o_t spmRsp;
  logic          busy;

  int total = 0;
  int bad   = 0;

  spm_load_splitter dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .core_req_i (coreReq),
    .core_req_o (coreRsp),
    .spm_req_o  (spmReq),
    .spm_req_i  (spmRsp),
    .busy_o     (busy)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Advance to just after the next rising edge, then let the new inputs settle.
  task automatic nextCycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic applyStimulus(input logic req, input logic we, input logic [11:0] idx,
                               input logic [43:0] tag, input logic [63:0] wdata,
                               input logic kill, input logic tagValid);
    coreReq.data_req      = req;
    coreReq.data_we       = we;
    coreReq.address_index = idx;
    coreReq.address_tag   = tag;
    coreReq.data_wdata    = wdata;
    coreReq.data_be       = 8'hFF;
    coreReq.data_size     = 2'd3;
    coreReq.kill_req      = kill;
    coreReq.tag_valid     = tagValid;
    #2;
  endtask

  task automatic idleInputs();
    applyStimulus(1'b0, 1'b0, 12'h0, 44'h0, 64'h0, 1'b0, 1'b0);
  endtask

  // In-window load at 0x7000_0010 answered by the controller one cycle after the request.
  task automatic runLoad(input string tag, input logic [63:0] rdata);
    applyStimulus(1'b1, 1'b0, 12'h010, 44'h0, 64'h0, 1'b0, 1'b0);
    checkOutput({tag, ".idxGnt"}, 64'(coreRsp.data_gnt), 64'd1);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 12'h0, 44'h70000, 64'h0, 1'b0, 1'b1);
    checkOutput({tag, ".tagGnt"}, 64'(coreRsp.data_gnt), 64'd0);
    checkOutput({tag, ".tagSpmReq"}, 64'(spmReq.data_req), 64'd0);
    nextCycle();
    idleInputs();
    checkOutput({tag, ".spmReq"}, 64'(spmReq.data_req), 64'd1);
    checkOutput({tag, ".spmIdx"}, 64'(spmReq.address_index), 64'h010);
    checkOutput({tag, ".spmTag"}, 64'(spmReq.address_tag), 64'h70000);
    checkOutput({tag, ".spmWe"}, 64'(spmReq.data_we), 64'd0);
    checkOutput({tag, ".earlyRvalid"}, 64'(coreRsp.data_rvalid), 64'd0);
    nextCycle();
    spmRsp.data_rvalid = 1'b1;
    spmRsp.data_rdata  = rdata;
    #2;
    checkOutput({tag, ".reqDrop"}, 64'(spmReq.data_req), 64'd0);
`ifdef SPM_SPLIT_RSP_REG_EN
    checkOutput({tag, ".noRvalidYet"}, 64'(coreRsp.data_rvalid), 64'd0);
    nextCycle();
    spmRsp.data_rvalid = 1'b0;
    spmRsp.data_rdata  = 64'h0;
    #2;
`endif
    checkOutput({tag, ".rvalid"}, 64'(coreRsp.data_rvalid), 64'd1);
    checkOutput({tag, ".rdata"}, coreRsp.data_rdata, rdata);
    nextCycle();
    spmRsp.data_rvalid = 1'b0;
    spmRsp.data_rdata  = 64'h0;
    #2;
    checkOutput({tag, ".idle"}, 64'(busy), 64'd0);
    checkOutput({tag, ".rvalidLow"}, 64'(coreRsp.data_rvalid), 64'd0);
  endtask

  initial begin
    int rvalidCount;
    logic [63:0] oowData;
    logic sawSpmReq;

    rst_i  = 1'b1;
    spmRsp = '0;
    coreReq = '0;
    idleInputs();
    $display("[TB] reset");
    checkOutput("rst.busy", 64'(busy), 64'd0);
    checkOutput("rst.spmReq", 64'(spmReq.data_req), 64'd0);
    checkOutput("rst.gnt", 64'(coreRsp.data_gnt), 64'd0);
    checkOutput("rst.rvalid", 64'(coreRsp.data_rvalid), 64'd0);
    nextCycle();
    nextCycle();
    rst_i = 1'b0;
    nextCycle();

    $display("[TB] in-window load");
    runLoad("load", 64'h1122334455667788);

    $display("[TB] killed load");
    applyStimulus(1'b1, 1'b0, 12'h020, 44'h0, 64'h0, 1'b0, 1'b0);
    checkOutput("kill.idxGnt", 64'(coreRsp.data_gnt), 64'd1);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 12'h0, 44'h70000, 64'h0, 1'b1, 1'b1);
    checkOutput("kill.spmReq0", 64'(spmReq.data_req), 64'd0);
    nextCycle();
    idleInputs();
    checkOutput("kill.busy", 64'(busy), 64'd0);
    checkOutput("kill.spmReq1", 64'(spmReq.data_req), 64'd0);
    checkOutput("kill.rvalid", 64'(coreRsp.data_rvalid), 64'd0);
    nextCycle();

    $display("[TB] out-of-window load");
    applyStimulus(1'b1, 1'b0, 12'h000, 44'h0, 64'h0, 1'b0, 1'b0);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 12'h0, 44'h80000, 64'h0, 1'b0, 1'b1);
    rvalidCount = 0;
    oowData     = 64'h0;
    sawSpmReq   = spmReq.data_req;
    for (int i = 0; i < 4; i++) begin
      nextCycle();
      idleInputs();
      if (coreRsp.data_rvalid) begin
        rvalidCount++;
        oowData = coreRsp.data_rdata;
      end
      if (spmReq.data_req) sawSpmReq = 1'b1;
    end
    checkOutput("oow.rvalidCount", 64'(rvalidCount), 64'd1);
    checkOutput("oow.rdata", oowData, 64'hCA11AB1E_BADCAB1E);
    checkOutput("oow.spmReq", 64'(sawSpmReq), 64'd0);
    checkOutput("oow.busy", 64'(busy), 64'd0);

    $display("[TB] in-window store at top of window");
    applyStimulus(1'b1, 1'b1, 12'hFF8, 44'h7001F, 64'hA5A5A5A5A5A5A5A5, 1'b0, 1'b1);
    checkOutput("st.noEarlyGnt", 64'(coreRsp.data_gnt), 64'd0);
    nextCycle();
    idleInputs();
    checkOutput("st.we", 64'(spmReq.data_we), 64'd1);
    checkOutput("st.wdata", spmReq.data_wdata, 64'hA5A5A5A5A5A5A5A5);
    checkOutput("st.be", 64'(spmReq.data_be), 64'hFF);
    checkOutput("st.tag", 64'(spmReq.address_tag), 64'h7001F);
    for (int i = 0; i < 4; i++) begin
      spmRsp.data_gnt = (i == 3);
      #2;
      checkOutput($sformatf("st.req%0d", i), 64'(spmReq.data_req), 64'd1);
      checkOutput($sformatf("st.gnt%0d", i), 64'(coreRsp.data_gnt), 64'(i == 3));
      nextCycle();
    end
    spmRsp.data_gnt = 1'b0;
    #2;
    checkOutput("st.idle", 64'(busy), 64'd0);
    checkOutput("st.reqLow", 64'(spmReq.data_req), 64'd0);

    $display("[TB] out-of-window stores");
    applyStimulus(1'b1, 1'b1, 12'h000, 44'h80000, 64'h1, 1'b0, 1'b1);
    checkOutput("oowSt.gnt", 64'(coreRsp.data_gnt), 64'd1);
    nextCycle();
    idleInputs();
    checkOutput("oowSt.idle", 64'(busy), 64'd0);
    checkOutput("oowSt.spmReq", 64'(spmReq.data_req), 64'd0);
    applyStimulus(1'b1, 1'b1, 12'h000, 44'h70020, 64'h2, 1'b0, 1'b1);
    checkOutput("edgeSt.gnt", 64'(coreRsp.data_gnt), 64'd1);
    nextCycle();
    idleInputs();
    checkOutput("edgeSt.idle", 64'(busy), 64'd0);

    $display("[TB] reset mid-load");
    applyStimulus(1'b1, 1'b0, 12'h040, 44'h0, 64'h0, 1'b0, 1'b0);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 12'h0, 44'h70000, 64'h0, 1'b0, 1'b1);
    nextCycle();
    idleInputs();
    checkOutput("rstMid.inLdReq", 64'(spmReq.data_req), 64'd1);
    rst_i = 1'b1;
    #1;
    checkOutput("rstMid.reqDrop", 64'(spmReq.data_req), 64'd0);
    checkOutput("rstMid.busy", 64'(busy), 64'd0);
    nextCycle();
    rst_i = 1'b0;
    nextCycle();
    runLoad("reload", 64'h0F0E0D0C0B0A0908);

    $display("[TB] test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
